// File: rtl/adc_rr_scheduler.sv
// Round-robin scheduler sharing one serial 10-bit ADC engine among NUM_REQ requesters.
// Optional WAIT timeout: define ADC_RR_SCHEDULER_TIMEOUT_EN.
module adc_rr_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic [NUM_REQ-1:0] DONE,
  output logic [9:0]         RESULT,
  output logic               ERR,
  output logic               ADC_START,
  input  logic               ADC_VALID,
  input  logic [9:0]         ADC_DATA,
  output logic               BUSY
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DELIVER = 3'd3;
  localparam logic [2:0] S_GUARD   = 3'd4;

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [2:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] pick;
  logic          any;
  logic [PW:0]   sum;
  logic [GW-1:0] gcnt;
  logic [TW-1:0] tcnt;
  logic          err_r;
  logic          tmo;

  // Rotating priority: search upward from ptr+1 and wrap.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    sum  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ))
        sum = sum - (PW+1)'(NUM_REQ);
      if (!any && REQ[sum[PW-1:0]]) begin
        any  = 1'b1;
        pick = sum[PW-1:0];
      end
    end
  end

`ifdef ADC_RR_SCHEDULER_TIMEOUT_EN
  assign tmo = (tcnt >= TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= PW'(NUM_REQ - 1);
      win       <= '0;
      GNT       <= '0;
      DONE      <= '0;
      RESULT    <= 10'h000;
      err_r     <= 1'b0;
      ADC_START <= 1'b0;
      gcnt      <= '0;
      tcnt      <= '0;
    end else begin
      ADC_START <= 1'b0;
      DONE      <= '0;
      case (state)
        S_IDLE: begin
          if (any) begin
            win   <= pick;
            ptr   <= pick;
            GNT   <= ONE << pick;
            state <= S_START;
          end
        end
        S_START: begin
          ADC_START <= 1'b1;
          tcnt      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // Valid data beats an expiring timeout in the same cycle.
          if (ADC_VALID) begin
            RESULT <= ADC_DATA;
            err_r  <= 1'b0;
            DONE   <= ONE << win;
            state  <= S_DELIVER;
          end else if (tmo) begin
            err_r <= 1'b1;
            DONE  <= ONE << win;
            state <= S_DELIVER;
          end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DELIVER: begin
          GNT   <= '0;
          err_r <= 1'b0;
          gcnt  <= '0;
          state <= S_GUARD;
        end
        S_GUARD: begin
          if (gcnt >= GW'(GUARD_CYCLES - 1))
            state <= S_IDLE;
          else
            gcnt <= gcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ERR  = err_r;
  assign BUSY = (state != S_IDLE);

endmodule
